sprite_line_evaluator: RTL and testbench

- Upstream stage of the sprite pixel renderer.
- During horizontal blanking it scans a sprite attribute table for the next logical line (256x192 canvas). It fetches the 8-bit bitmap row of each sprite that hits that line and fills a small slot buffer.
- The slot buffer is double-buffered. The renderer reads a stable "display" copy while the next line is evaluated into a "working" copy.

---
 rtl/sprite_pkg.sv | 37 +++
 rtl/sprite_slot_bank.sv | 84 ++++++++
 rtl/sprite_line_evaluator.sv | 185 ++++++++++++++++++
 tb/tb_sprite_line_evaluator.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line evaluator.
// SPRITE_FLIP_EN widens the attribute word to carry vflip/hflip bits.
package sprite_pkg;

   localparam int unsigned SPR_SIZE  = 8;
   localparam int unsigned LOGICAL_W = 256;
   localparam int unsigned LOGICAL_H = 192;

`ifdef SPRITE_FLIP_EN
   localparam int unsigned ATTR_W = 18;
`else
   localparam int unsigned ATTR_W = 16;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StAttrReq,
      StAttrChk,
      StRowReq,
      StRowStore
   } eval_state_e;

   typedef struct packed {
      logic       valid;
      logic [7:0] x;
      logic [7:0] row;
   } slot_t;

   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/sprite_slot_bank.sv
// Double-buffered slot storage: working set filled by the scan, display set
// updated only on commit.
module sprite_slot_bank
   import sprite_pkg::*;
#(
   parameter int unsigned SLOTS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 wr_en,
   input  logic [7:0]           wr_x,
   input  logic [7:0]           wr_row,
   input  logic                 set_ovf,
   input  logic                 commit,
   output logic                 full,
   output logic [SLOTS-1:0]     slot_valid,
   output logic [8*SLOTS-1:0]   slot_x,
   output logic [8*SLOTS-1:0]   slot_row,
   output logic                 overflow
);

   localparam int unsigned CNT_W = $clog2(SLOTS + 1);

   slot_t            work_q [SLOTS];
   slot_t            disp_q [SLOTS];
   logic [CNT_W-1:0] fill_q;
   logic             work_ovf_q;
   logic             disp_ovf_q;

   assign full     = (fill_q == CNT_W'(SLOTS));
   assign overflow = disp_ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            work_q[i] <= '0;
            disp_q[i] <= '0;
         end
         fill_q     <= '0;
         work_ovf_q <= 1'b0;
         disp_ovf_q <= 1'b0;
      end else begin
         // Commit samples the working set as it stood before any same-cycle clear or write.
         if (commit) begin
            for (int i = 0; i < SLOTS; i++) begin
               disp_q[i] <= work_q[i];
            end
            disp_ovf_q <= work_ovf_q;
         end
         if (clear) begin
            for (int i = 0; i < SLOTS; i++) begin
               work_q[i] <= '0;
            end
            fill_q     <= '0;
            work_ovf_q <= 1'b0;
         end else begin
            if (wr_en && !full) begin
               for (int i = 0; i < SLOTS; i++) begin
                  if (fill_q == CNT_W'(i)) begin
                     work_q[i] <= slot_t'{valid: 1'b1, x: wr_x, row: wr_row};
                  end
               end
               fill_q <= fill_q + CNT_W'(1);
            end
            if (set_ovf) begin
               work_ovf_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      slot_valid = '0;
      slot_x     = '0;
      slot_row   = '0;
      for (int i = 0; i < SLOTS; i++) begin
         slot_valid[i]     = disp_q[i].valid;
         slot_x[8*i +: 8]   = disp_q[i].x;
         slot_row[8*i +: 8] = disp_q[i].row;
      end
   end

endmodule

// File: rtl/sprite_line_evaluator.sv
// Scans the sprite attribute table for the next line and fills the slot bank.
// Define SPRITE_FLIP_EN for per-sprite vertical/horizontal flip.
module sprite_line_evaluator
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_SPRITES = 8,
   parameter int unsigned SLOTS       = 4,
   parameter int unsigned IDX_W       = $clog2(NUM_SPRITES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 line_start,
   input  logic [7:0]           next_ly,
   input  logic                 line_commit,
   output logic                 attr_rd_en,
   output logic [IDX_W-1:0]     attr_rd_idx,
   input  logic [ATTR_W-1:0]    attr_rd_data,
   output logic                 row_rd_en,
   output logic [IDX_W+2:0]     row_rd_addr,
   input  logic [7:0]           row_rd_data,
   output logic [SLOTS-1:0]     slot_valid,
   output logic [8*SLOTS-1:0]   slot_x,
   output logic [8*SLOTS-1:0]   slot_row,
   output logic                 busy,
   output logic                 overflow,
   output logic                 late_err
);

   eval_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       ly_q, ly_d;
   logic [7:0]       x_q, x_d;
   logic [2:0]       row_q, row_d;
   logic             late_err_q;

   logic [7:0]       attr_y;
   logic [7:0]       attr_x;
   logic [2:0]       hit_row;
   logic             hit;
   logic             last_idx;
   logic [7:0]       store_row;

   logic             bank_full;
   logic             bank_clear;
   logic             bank_wr;
   logic             bank_set_ovf;

   assign attr_y   = attr_rd_data[15:8];
   assign attr_x   = attr_rd_data[7:0];
   // Low three bits of (ly - y) depend only on the low three bits of each operand.
   assign hit_row  = ly_q[2:0] - attr_y[2:0];
   assign hit      = ({1'b0, ly_q} >= {1'b0, attr_y}) &&
                     ({1'b0, ly_q} < ({1'b0, attr_y} + 9'(SPR_SIZE)));
   assign last_idx = (idx_q == IDX_W'(NUM_SPRITES - 1));

`ifdef SPRITE_FLIP_EN
   logic hflip_q, hflip_d;
   logic vflip;

   assign vflip     = attr_rd_data[17];
   assign store_row = hflip_q ? bit_rev8(row_rd_data) : row_rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         hflip_q <= 1'b0;
      end else begin
         hflip_q <= hflip_d;
      end
   end
`else
   assign store_row = row_rd_data;
`endif

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      ly_d         = ly_q;
      x_d          = x_q;
      row_d        = row_q;
      attr_rd_en   = 1'b0;
      row_rd_en    = 1'b0;
      bank_clear   = 1'b0;
      bank_wr      = 1'b0;
      bank_set_ovf = 1'b0;
`ifdef SPRITE_FLIP_EN
      hflip_d      = hflip_q;
`endif

      unique case (state_q)
         StIdle: ;
         StAttrReq: begin
            attr_rd_en = 1'b1;
            state_d    = StAttrChk;
         end
         StAttrChk: begin
            if (hit) begin
               if (bank_full) begin
                  bank_set_ovf = 1'b1;
                  state_d      = StIdle;
               end else begin
                  x_d     = attr_x;
`ifdef SPRITE_FLIP_EN
                  row_d   = hit_row ^ {3{vflip}};
                  hflip_d = attr_rd_data[16];
`else
                  row_d   = hit_row;
`endif
                  state_d = StRowReq;
               end
            end else if (last_idx) begin
               state_d = StIdle;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = StAttrReq;
            end
         end
         StRowReq: begin
            row_rd_en = 1'b1;
            state_d   = StRowStore;
         end
         StRowStore: begin
            bank_wr = 1'b1;
            if (last_idx) begin
               state_d = StIdle;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = StAttrReq;
            end
         end
         default: state_d = StIdle;
      endcase

      // A new line always wins: abort any scan in flight and restart from sprite 0.
      if (line_start) begin
         bank_clear   = 1'b1;
         bank_wr      = 1'b0;
         bank_set_ovf = 1'b0;
         ly_d         = next_ly;
         idx_d        = '0;
         state_d      = StAttrReq;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         ly_q       <= '0;
         x_q        <= '0;
         row_q      <= '0;
         late_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ly_q       <= ly_d;
         x_q        <= x_d;
         row_q      <= row_d;
         late_err_q <= line_commit && busy;
      end
   end

   assign busy        = (state_q != StIdle);
   assign attr_rd_idx = idx_q;
   assign row_rd_addr = {idx_q, row_q};
   assign late_err    = late_err_q;

   sprite_slot_bank #(
      .SLOTS (SLOTS)
   ) u_slot_bank (
      .clk        (clk),
      .rst        (rst),
      .clear      (bank_clear),
      .wr_en      (bank_wr),
      .wr_x       (x_q),
      .wr_row     (store_row),
      .set_ovf    (bank_set_ovf),
      .commit     (line_commit),
      .full       (bank_full),
      .slot_valid (slot_valid),
      .slot_x     (slot_x),
      .slot_row   (slot_row),
      .overflow   (overflow)
   );

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Bench for sprite_line_evaluator: timeline-based reference model of each scan,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sprite_line_evaluator;

   localparam int unsigned NS = 8;
   localparam int unsigned SL = 4;
   localparam int unsigned IW = $clog2(NS);
`ifdef SPRITE_FLIP_EN
   localparam int unsigned AW = 18;
`else
   localparam int unsigned AW = 16;
`endif

   logic            clk, rst, line_start, line_commit;
   logic [7:0]      next_ly, row_rd_data;
   logic            attr_rd_en, row_rd_en, busy, overflow, late_err;
   logic [IW-1:0]   attr_rd_idx;
   logic [IW+2:0]   row_rd_addr;
   logic [AW-1:0]   attr_rd_data;
   logic [SL-1:0]   slot_valid;
   logic [8*SL-1:0] slot_x, slot_row;

   sprite_line_evaluator #(
      .NUM_SPRITES (NS),
      .SLOTS       (SL),
      .IDX_W       (IW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .line_start   (line_start),
      .next_ly      (next_ly),
      .line_commit  (line_commit),
      .attr_rd_en   (attr_rd_en),
      .attr_rd_idx  (attr_rd_idx),
      .attr_rd_data (attr_rd_data),
      .row_rd_en    (row_rd_en),
      .row_rd_addr  (row_rd_addr),
      .row_rd_data  (row_rd_data),
      .slot_valid   (slot_valid),
      .slot_x       (slot_x),
      .slot_row     (slot_row),
      .busy         (busy),
      .overflow     (overflow),
      .late_err     (late_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attribute/bitmap memories: one-cycle read latency, garbage when not read.
   logic [15:0] attr_mem [NS];
   logic [7:0]  row_mem  [NS*8];

   always @(posedge clk) begin
      attr_rd_data <= attr_rd_en ? AW'(attr_mem[attr_rd_idx]) : AW'($urandom);
      row_rd_data  <= row_rd_en ? row_mem[row_rd_addr] : 8'($urandom);
   end

   // Reference model: each scan is a timeline of offsets from its first cycle.
   int  cyc, n_vec, n_err;
   bit  checking, scan_active;
   int  scan_start, scan_len, n_ent, n_ar, ovf_t;
   int  ar_t [NS];
   int  ent_ready [SL], ent_rreq [SL], ent_addr [SL], ent_x [SL], ent_row [SL];
   bit  exp_valid [SL];
   int  exp_x [SL], exp_row [SL];
   bit  exp_ovf, exp_late;
   int  n_ar_seen, n_rr_seen, n_busy, n_late, last_raddr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 30)
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit busy_at(input int c);
      return scan_active && c >= scan_start && c < scan_start + scan_len;
   endfunction

   // Each sprite costs 2 cycles to check; a stored hit costs 2 more.
   task automatic build_scan(input int ly);
      int t = 0;
      n_ent = 0;
      n_ar  = 0;
      ovf_t = -1;
      for (int i = 0; i < NS; i++) begin
         int y = int'(attr_mem[i][15:8]);
         ar_t[n_ar] = t;
         n_ar++;
         if (ly >= y && ly < y + 8) begin
            if (n_ent == SL) begin
               ovf_t = t + 2;
               t += 2;
               break;
            end
            ent_rreq[n_ent]  = t + 2;
            ent_ready[n_ent] = t + 4;
            ent_addr[n_ent]  = i * 8 + (ly - y);
            ent_x[n_ent]     = int'(attr_mem[i][7:0]);
            ent_row[n_ent]   = int'(row_mem[i * 8 + (ly - y)]);
            n_ent++;
            t += 4;
         end else begin
            t += 2;
         end
      end
      scan_len = t;
   endtask

   task automatic model_update(input int c);
      if (rst) begin
         scan_active = 0;
         exp_ovf     = 0;
         exp_late    = 0;
         for (int i = 0; i < SL; i++) begin
            exp_valid[i] = 0;
            exp_x[i]     = 0;
            exp_row[i]   = 0;
         end
         checking = 1;
         return;
      end
      exp_late = line_commit && busy_at(c);
      if (line_commit) begin
         for (int i = 0; i < SL; i++) begin
            bit v = scan_active && i < n_ent && (c - scan_start) >= ent_ready[i];
            exp_valid[i] = v;
            exp_x[i]     = v ? ent_x[i] : 0;
            exp_row[i]   = v ? ent_row[i] : 0;
         end
         exp_ovf = scan_active && ovf_t >= 0 && (c - scan_start) >= ovf_t;
      end
      if (line_start) begin
         build_scan(int'(next_ly));
         scan_start  = c + 1;
         scan_active = 1;
      end
   endtask

   task automatic compare(input int c);
      logic [SL-1:0]   ev;
      logic [8*SL-1:0] ex, er;
      bit              ear, erd;
      int              eidx, eaddr;
      int              off = c - scan_start;
      ev = '0;
      ex = '0;
      er = '0;
      for (int i = 0; i < SL; i++) begin
         ev[i]         = exp_valid[i];
         ex[8*i +: 8] = 8'(exp_x[i]);
         er[8*i +: 8] = 8'(exp_row[i]);
      end
      ear = 0;
      erd = 0;
      eidx = 0;
      eaddr = 0;
      if (busy_at(c)) begin
         for (int i = 0; i < n_ar; i++)
            if (ar_t[i] == off) begin ear = 1; eidx = i; end
         for (int i = 0; i < n_ent; i++)
            if (ent_rreq[i] == off) begin erd = 1; eaddr = ent_addr[i]; end
      end
      chk("busy", 32'(busy), 32'(busy_at(c)));
      chk("late_err", 32'(late_err), 32'(exp_late));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("slot_valid", 32'(slot_valid), 32'(ev));
      chk("slot_x", 32'(slot_x), 32'(ex));
      chk("slot_row", 32'(slot_row), 32'(er));
      chk("attr_rd_en", 32'(attr_rd_en), 32'(ear));
      if (ear) chk("attr_rd_idx", 32'(attr_rd_idx), 32'(eidx));
      chk("row_rd_en", 32'(row_rd_en), 32'(erd));
      if (erd) chk("row_rd_addr", 32'(row_rd_addr), 32'(eaddr));
      if (attr_rd_en) n_ar_seen++;
      if (row_rd_en) begin n_rr_seen++; last_raddr = int'(row_rd_addr); end
      if (busy) n_busy++;
      if (late_err) n_late++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update(cyc);
      cyc++;
      @(negedge clk);
      if (checking) compare(cyc);
   endtask

   task automatic clr_counts();
      n_ar_seen = 0; n_rr_seen = 0; n_busy = 0; n_late = 0; last_raddr = -1;
   endtask

   task automatic start_line(input int ly);
      next_ly    = 8'(ly);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic commit();
      line_commit = 1'b1;
      tick();
      line_commit = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 200) begin tick(); k++; end
      chk("scan_finishes", 32'(busy), 32'd0);
   endtask

   task automatic fill_attr(input int y);
      for (int i = 0; i < NS; i++) attr_mem[i] = {8'(y), 8'(i)};
   endtask

   initial begin
      cyc = 0; n_vec = 0; n_err = 0; checking = 0; scan_active = 0;
      scan_start = 0; scan_len = 0; n_ent = 0; n_ar = 0; ovf_t = -1;
      rst = 1'b1; line_start = 1'b0; line_commit = 1'b0; next_ly = 8'd0;
      fill_attr(200);
      for (int i = 0; i < NS * 8; i++) row_mem[i] = 8'($urandom);
      clr_counts();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_attr_idx", 32'(attr_rd_idx), 32'd0);
      chk("rst_row_addr", 32'(row_rd_addr), 32'd0);

      // All sprites far below the line: eight checks, no row fetches.
      clr_counts();
      start_line(5);
      wait_idle();
      chk("t1_busy_cycles", 32'(n_busy), 32'd16);
      chk("t1_attr_reads", 32'(n_ar_seen), 32'd8);
      chk("t1_row_reads", 32'(n_rr_seen), 32'd0);
      commit();
      chk("t1_slot_valid", 32'(slot_valid), 32'd0);
      chk("t1_overflow", 32'(overflow), 32'd0);

      // Single hit: sprite 2 at (10,5), line 7 -> row 2.
      attr_mem[2] = {8'd5, 8'd10};
      row_mem[2*8+2] = 8'hA5;
      clr_counts();
      start_line(7);
      wait_idle();
      chk("t2_row_addr", 32'(last_raddr), 32'd18);
      commit();
      chk("t2_slot_valid", 32'(slot_valid), 32'h1);
      chk("t2_slot0_x", 32'(slot_x[7:0]), 32'd10);
      chk("t2_slot0_row", 32'(slot_row[7:0]), 32'hA5);

      // Six hits with four slots: overflow, scan stops at sprite 4.
      fill_attr(200);
      for (int i = 0; i < 6; i++) attr_mem[i] = {8'd20, 8'(i * 10 + 1)};
      clr_counts();
      start_line(22);
      wait_idle();
      chk("t3_attr_reads", 32'(n_ar_seen), 32'd5);
      chk("t3_row_reads", 32'(n_rr_seen), 32'd4);
      commit();
      chk("t3_overflow", 32'(overflow), 32'd1);
      chk("t3_slot_valid", 32'(slot_valid), 32'hF);
      chk("t3_slot_x", 32'(slot_x), 32'h1F150B01);

      // Bottom edge: y=252 reaches line 255 but never wraps to line 3.
      fill_attr(200);
      attr_mem[0] = {8'd252, 8'd7};
      clr_counts();
      start_line(255);
      wait_idle();
      chk("t4_hit_addr", 32'(last_raddr), 32'd3);
      clr_counts();
      start_line(3);
      wait_idle();
      chk("t4_nowrap_rows", 32'(n_rr_seen), 32'd0);

      // Late commit five cycles after line_start.
      fill_attr(200);
      for (int i = 0; i < 6; i++) attr_mem[i] = {8'd20, 8'(i * 10 + 1)};
      clr_counts();
      start_line(22);
      repeat (4) tick();
      commit();
      chk("t5_partial_valid", 32'(slot_valid), 32'h1);
      wait_idle();
      chk("t5_late_pulses", 32'(n_late), 32'd1);
      commit();
      chk("t5_full_valid", 32'(slot_valid), 32'hF);

      // Commit and start together: display takes the finished line.
      next_ly = 8'd23; line_start = 1'b1; line_commit = 1'b1;
      tick();
      line_start = 1'b0; line_commit = 1'b0;
      chk("t6_same_cycle_valid", 32'(slot_valid), 32'hF);
      chk("t6_same_cycle_ovf", 32'(overflow), 32'd1);
      // Restart mid-scan, then reset mid-scan.
      repeat (6) tick();
      start_line(24);
      wait_idle();
      commit();
      chk("t6_restart_x", 32'(slot_x), 32'h1F150B01);
      start_line(22);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_valid", 32'(slot_valid), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_attr_en", 32'(attr_rd_en), 32'd0);

      // Randomised lines, commits and aborts against the model.
      for (int it = 0; it < 80; it++) begin
         int ly = int'($urandom_range(0, 255));
         int mode = int'($urandom_range(0, 3));
         for (int i = 0; i < NS; i++) begin
            logic [7:0] y;
            y = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                            : 8'(ly - int'($urandom_range(0, 12)));
            attr_mem[i] = {y, 8'($urandom)};
         end
         for (int i = 0; i < NS * 8; i++) row_mem[i] = 8'($urandom);
         start_line(ly);
         case (mode)
            0: begin wait_idle(); commit(); end
            1: begin
               repeat ($urandom_range(0, 20)) tick();
               commit();
               wait_idle();
               commit();
            end
            2: begin
               repeat ($urandom_range(0, 15)) tick();
               start_line(int'($urandom_range(0, 255)));
               wait_idle();
               commit();
            end
            default: begin
               wait_idle();
               next_ly = 8'($urandom); line_start = 1'b1; line_commit = 1'b1;
               tick();
               line_start = 1'b0; line_commit = 1'b0;
               wait_idle();
               commit();
            end
         endcase
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
